// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 registers plus the exception/interrupt entry and ERET sequencer
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_RST = 32'h0000_0008,
  parameter int          ERET_HOLD   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_unrecognized,
  input  logic [1:0]  id_cp_oper,
  input  logic        is_branch_exe,
  input  logic        ext_int,
  input  logic [4:0]  cp_raddr,
  output logic [31:0] cp_rdata,
  input  logic        cp_wen,
  input  logic [4:0]  cp_waddr,
  input  logic [31:0] cp_wdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [1:0]  exc_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SLOT = 2'd1, HOLD = 2'd2} state_t;
  state_t      state;
  logic        ie, exl, ip;
  logic [4:0]  exc_code;
  logic [31:0] epc, handler;
  logic [3:0]  cnt;
  logic        exc_ri, int_pend, int_ok, entry, do_eret;
  always_comb begin
    exc_ri      = id_valid & id_unrecognized & ~exl;
    int_pend    = ip & ie & ~exl;
    int_ok      = int_pend & id_valid & ~is_branch_exe & (state != HOLD);
    entry       = exc_ri | int_ok;
    do_eret     = id_valid & (id_cp_oper == 2'b10) & ~id_unrecognized & ~entry;
    redirect    = ~rst & (entry | do_eret);
    flush       = redirect;
    redirect_pc = entry ? handler : epc;
    exc_state   = state;
    cp_rdata    = cp_raddr == 5'd12 ? {30'd0, exl, ie} :
                  cp_raddr == 5'd13 ? {21'd0, ip, 3'd0, exc_code, 2'd0} :
                  cp_raddr == 5'd14 ? epc :
                  cp_raddr == 5'd16 ? handler : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      ip       <= 1'b0;
      exc_code <= 5'd0;
      epc      <= 32'd0;
      handler  <= HANDLER_RST;
      cnt      <= 4'd0;
      state    <= IDLE;
    end else begin
      ip <= ext_int | (ip & ~(int_ok & ~exc_ri));
      if (cp_wen) begin
        if (cp_waddr == 5'd12) {exl, ie} <= cp_wdata[1:0];
        if (cp_waddr == 5'd13) exc_code <= cp_wdata[6:2];
        if (cp_waddr == 5'd14) epc <= cp_wdata;
        if (cp_waddr == 5'd16) handler <= cp_wdata;
      end
      // entry/ERET updates come after the mtc0 write so they take precedence
      if (entry) begin
        epc      <= id_pc;
        exl      <= 1'b1;
        exc_code <= exc_ri ? 5'd10 : 5'd0;
        state    <= IDLE;
      end else if (do_eret) begin
        exl   <= 1'b0;
        cnt   <= 4'(ERET_HOLD);
        state <= HOLD;
      end else begin
        case (state)
          IDLE:      state <= int_pend ? WAIT_SLOT : IDLE;
          WAIT_SLOT: state <= int_pend ? WAIT_SLOT : IDLE;
          HOLD: begin
            cnt   <= cnt - 4'd1;
            state <= cnt <= 4'd1 ? IDLE : HOLD;
          end
          default:   state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed scenario tests for the CP0 exception controller
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_unrecognized, is_branch_exe, ext_int, cp_wen;
  logic [31:0] id_pc, cp_wdata, cp_rdata, redirect_pc;
  logic [1:0]  id_cp_oper, exc_state;
  logic [4:0]  cp_raddr, cp_waddr;
  logic        redirect, flush;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] rv;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_unrecognized(id_unrecognized), .id_cp_oper(id_cp_oper),
    .is_branch_exe(is_branch_exe), .ext_int(ext_int), .cp_raddr(cp_raddr),
    .cp_rdata(cp_rdata), .cp_wen(cp_wen), .cp_waddr(cp_waddr), .cp_wdata(cp_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .exc_state(exc_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_unrecognized = 0; id_cp_oper = 2'b00; is_branch_exe = 0;
    ext_int = 0; cp_wen = 0; cp_waddr = 0; cp_wdata = 0; id_pc = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp_raddr = a;
    #1;
    d = cp_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp_wen = 1; cp_waddr = a; cp_wdata = d;
    tick();
    cp_wen = 0;
  endtask

  task automatic test_reset();
    rst = 1; id_valid = 1; id_unrecognized = 1; id_pc = 32'h44;
    #1;
    tests++; if (redirect !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL reset_outputs redirect=%b flush=%b want 0 0", redirect, flush); end
    tick();
    idle_inputs();
    rst = 0;
    rd(5'd16, rv); tests++; if (rv !== 32'h8) begin fails++; $display("FAIL reset_handler got %h want 00000008", rv); end
    rd(5'd12, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_status got %h want 0", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_cause got %h want 0", rv); end
    rd(5'd14, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_epc got %h want 0", rv); end
    tests++; if (exc_state !== 2'd0 || redirect !== 1'b0) begin fails++; $display("FAIL reset_state state=%0d redirect=%b want 0 0", exc_state, redirect); end
    tick();
  endtask

  task automatic test_exc_ri();
    wr(5'd12, 32'h3);
    id_valid = 1; id_unrecognized = 1; id_pc = 32'h40;
    #1;
    tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL ri_masked_by_exl redirect=%b want 0", redirect); end
    tick();
    idle_inputs();
    wr(5'd12, 32'h1);
    id_valid = 1; id_unrecognized = 1; id_pc = 32'h40;
    #1;
    tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h8 || flush !== 1'b1) begin fails++; $display("FAIL ri_entry redirect=%b pc=%h flush=%b want 1 00000008 1", redirect, redirect_pc, flush); end
    tick();
    idle_inputs();
    rd(5'd14, rv); tests++; if (rv !== 32'h40) begin fails++; $display("FAIL ri_epc got %h want 00000040", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h28) begin fails++; $display("FAIL ri_cause got %h want 00000028", rv); end
    rd(5'd12, rv); tests++; if (rv !== 32'h3) begin fails++; $display("FAIL ri_status got %h want 00000003", rv); end
    tests++; if (redirect !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL ri_deassert redirect=%b flush=%b want 0 0", redirect, flush); end
  endtask

  task automatic test_int_wait_slot();
    wr(5'd12, 32'h1);
    id_valid = 1; id_pc = 32'h100; is_branch_exe = 1; ext_int = 1;
    tick();
    ext_int = 0;
    #1;
    tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL int_delay_slot redirect=%b want 0", redirect); end
    tick();
    tests++; if (exc_state !== 2'd1 || redirect !== 1'b0) begin fails++; $display("FAIL int_wait_slot state=%0d redirect=%b want 1 0", exc_state, redirect); end
    is_branch_exe = 0; id_pc = 32'h104;
    #1;
    tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h8 || flush !== 1'b1) begin fails++; $display("FAIL int_entry redirect=%b pc=%h flush=%b want 1 00000008 1", redirect, redirect_pc, flush); end
    tick();
    idle_inputs();
    rd(5'd14, rv); tests++; if (rv !== 32'h104) begin fails++; $display("FAIL int_epc got %h want 00000104", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL int_cause got %h want 0", rv); end
    tests++; if (exc_state !== 2'd0) begin fails++; $display("FAIL int_state got %0d want 0", exc_state); end
  endtask

  task automatic test_eret_hold();
    id_valid = 1; id_cp_oper = 2'b10; ext_int = 1; id_pc = 32'h1F0;
    #1;
    tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h104 || flush !== 1'b1) begin fails++; $display("FAIL eret redirect=%b pc=%h flush=%b want 1 00000104 1", redirect, redirect_pc, flush); end
    tick();
    id_cp_oper = 2'b00; id_pc = 32'h200;
    rd(5'd12, rv); tests++; if (rv !== 32'h1) begin fails++; $display("FAIL eret_status got %h want 00000001", rv); end
    tests++; if (exc_state !== 2'd2) begin fails++; $display("FAIL eret_hold_state got %0d want 2", exc_state); end
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (redirect !== 1'b0) begin fails++; $display("FAIL eret_hold_block%0d redirect=%b want 0", i, redirect); end
      tick();
    end
    #1;
    tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h8) begin fails++; $display("FAIL eret_hold_release redirect=%b pc=%h want 1 00000008", redirect, redirect_pc); end
    tick();
    idle_inputs();
    rd(5'd14, rv); tests++; if (rv !== 32'h200) begin fails++; $display("FAIL hold_entry_epc got %h want 00000200", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h400) begin fails++; $display("FAIL hold_entry_cause got %h want 00000400", rv); end
  endtask

  task automatic test_simultaneous();
    wr(5'd12, 32'h1);
    id_valid = 1; id_unrecognized = 1; ext_int = 1; id_pc = 32'h300;
    cp_wen = 1; cp_waddr = 5'd14; cp_wdata = 32'hDEAD;
    #1;
    tests++; if (redirect !== 1'b1 || redirect_pc !== 32'h8) begin fails++; $display("FAIL simul_entry redirect=%b pc=%h want 1 00000008", redirect, redirect_pc); end
    tick();
    idle_inputs();
    rd(5'd14, rv); tests++; if (rv !== 32'h300) begin fails++; $display("FAIL simul_epc got %h want 00000300", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h428) begin fails++; $display("FAIL simul_cause got %h want 00000428", rv); end
  endtask

  task automatic test_reset_in_wait();
    wr(5'd12, 32'h1);
    tick();
    tests++; if (exc_state !== 2'd1) begin fails++; $display("FAIL pre_reset_wait state=%0d want 1", exc_state); end
    rst = 1; id_valid = 1; ext_int = 1;
    #1;
    tests++; if (redirect !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL reset_wait_outputs redirect=%b flush=%b want 0 0", redirect, flush); end
    tick();
    rst = 0; idle_inputs();
    tests++; if (exc_state !== 2'd0 || redirect !== 1'b0) begin fails++; $display("FAIL reset_wait_state state=%0d redirect=%b want 0 0", exc_state, redirect); end
    rd(5'd12, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_wait_status got %h want 0", rv); end
    rd(5'd13, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_wait_cause got %h want 0", rv); end
    rd(5'd14, rv); tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_wait_epc got %h want 0", rv); end
    rd(5'd16, rv); tests++; if (rv !== 32'h8) begin fails++; $display("FAIL reset_wait_handler got %h want 00000008", rv); end
  endtask

  initial begin
    idle_inputs();
    cp_raddr = 0;
    rst = 1;
    tick();
    test_reset();
    test_exc_ri();
    test_int_wait_slot();
    test_eret_hold();
    test_simultaneous();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
